// File: rtl/ysyx_2022040010_ctrl.sv
// rtl/ysyx_2022040010_ctrl.sv - pipeline hazard controller: stall/flush/halt generation plus optional perf counters
//
// Purpose : Resolves pipeline hazards for a 5-stage core by producing per-register
//           hold (stall) and bubble (flush) enables. Also drops one stale fetch
//           response after a redirect, and freezes the pipeline after ebreak.
// Ports   : clk, rst (async, active-high)
//           id_load_use, ex_busy, ex_br_taken       - hazard sources
//           imem_req/imem_ready, dmem_req/dmem_ready - memory handshakes
//           wb_ebreak                               - ebreak retiring in WB
//           stall[4:0], flush[4:0]                  - [0] PC .. [4] MEM/WB
//           halt                                    - pipeline permanently frozen
//           perf_cycle, perf_stall, perf_flush      - CNT_W-bit counters
// Config  : YSYX_2022040010_CTRL_PERF_EN builds the counters; otherwise perf_* are 0.
module ysyx_2022040010_ctrl #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_load_use,
    input  logic             ex_busy,
    input  logic             ex_br_taken,
    input  logic             imem_req,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             wb_ebreak,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             halt,
    output logic [CNT_W-1:0] perf_cycle,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DROP = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic dwait;
    logic iwait;

    assign dwait = dmem_req & ~dmem_ready;
    assign iwait = imem_req & ~imem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Branches in the priority chain are ordered highest priority first.
    always_comb begin
        stall   = 5'b00000;
        flush   = 5'b00000;
        halt    = 1'b0;
        state_d = state_q;
        if (rst) begin
            state_d = S_RUN;
        end else if (state_q == S_HALT || wb_ebreak) begin
            stall   = 5'b11111;
            halt    = 1'b1;
            state_d = S_HALT;
        end else if (dwait) begin
            // A taken branch waits frozen in EX until the higher condition clears.
            stall = 5'b01111;
            flush = 5'b10000;
        end else if (ex_busy) begin
            stall = 5'b00111;
            flush = 5'b01000;
        end else if (id_load_use) begin
            stall = 5'b00011;
            flush = 5'b00100;
        end else if (iwait) begin
            if (ex_br_taken) begin
                // PC takes the redirect now; the in-flight fetch for the old path
                // will still return and must be discarded in DROP.
                flush   = 5'b00110;
                state_d = S_DROP;
            end else begin
                stall = 5'b00001;
                flush = 5'b00010;
            end
        end else begin
            if (ex_br_taken) begin
                flush = 5'b00110;
            end
            if (state_q == S_DROP && imem_ready) begin
                flush[1] = 1'b1;
                state_d  = S_RUN;
            end
        end
    end

`ifdef YSYX_2022040010_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_cycle_q, perf_cycle_d;
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_cycle_d = perf_cycle_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (state_q != S_HALT) begin
            perf_cycle_d = perf_cycle_q + CNT_W'(1);
        end
        if (state_q != S_HALT && stall != 5'b00000) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
        if (flush != 5'b00000) begin
            perf_flush_d = perf_flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycle_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_cycle_q <= perf_cycle_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_cycle = perf_cycle_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_cycle = '0;
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: doc/ysyx_2022040010_ctrl.md
YSYX_2022040010_CTRL -- requirements
Module: ysyx_2022040010_ctrl

Interface
REQ-001 Parameter CNT_W, default 64, width of each performance counter.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 id_load_use  in  1  ID instruction reads the rd of the load currently in EX.
REQ-005 ex_busy  in  1  multi-cycle mul/div in EX has not finished.
REQ-006 ex_br_taken  in  1  EX resolves a taken branch or jump this cycle.
REQ-007 imem_req / imem_ready  in  1/1  fetch request outstanding / fetch data returned this cycle.
REQ-008 dmem_req / dmem_ready  in  1/1  MEM load or store outstanding / data access completes this cycle.
REQ-009 wb_ebreak  in  1  valid ebreak is in WB this cycle.
REQ-010 stall  out  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
REQ-011 flush  out  5  bubble enables with the same bit mapping; a flushed register loads all-zero, so pc=0 marks a bubble.
REQ-012 halt  out  1  pipeline permanently frozen after ebreak.
REQ-013 perf_cycle, perf_stall, perf_flush  out  CNT_W each  performance counters.

Function
REQ-014 States: RUN, DROP (discard one stale fetch response), HALT; encoding is free.
REQ-015 Conditions: dwait = dmem_req & ~dmem_ready; iwait = imem_req & ~imem_ready.
REQ-016 Priority, highest first: HALT > dwait > ex_busy > id_load_use > iwait > ex_br_taken > DROP discard.
REQ-017 HALT, or wb_ebreak in any state: stall = 5'b11111, flush = 0, halt = 1.
REQ-018 dwait: stall = 5'b01111, flush = 5'b10000.
REQ-019 ex_busy (no dwait): stall = 5'b00111, flush = 5'b01000.
REQ-020 id_load_use (no higher condition): stall = 5'b00011, flush = 5'b00100; lasts exactly the cycles id_load_use is high.
REQ-021 iwait (no higher condition): stall = 5'b00001, flush = 5'b00010.
REQ-022 ex_br_taken (no higher condition): stall = 0, flush = 5'b00110; PC loads the redirect target that edge.
REQ-023 ex_br_taken together with iwait: flush = 5'b00110, stall[0] = 0, next state DROP.
REQ-024 ex_br_taken together with dwait or ex_busy: no flush; the branch stays frozen in EX and is acted on in the first cycle the higher condition clears.
REQ-025 DROP: the first cycle with imem_ready = 1 asserts flush[1] (stale instruction killed), then state goes to RUN; DROP holds until that response arrives, and a second taken branch while in DROP does not re-enter DROP.
REQ-026 stall & flush == 0 in every cycle, bitwise.
REQ-027 Every output is a combinational function of the current state and inputs, so zero-cycle latency; only the state and counters are registered.
REQ-028 RUN/DROP -> HALT on any cycle with wb_ebreak = 1; HALT exits only through reset.
REQ-029 perf_cycle +1 every cycle not in HALT; perf_stall +1 when stall != 0 and not HALT; perf_flush +1 when flush != 0; all counters wrap modulo 2^CNT_W.

Reset
REQ-030 rst = 1 forces state RUN, halt = 0, all counters 0, immediately and independent of clk.
REQ-031 During reset, stall = 0 and flush = 0, regardless of inputs.
REQ-032 Reset asserted mid-DROP or mid-HALT abandons that state; the first post-reset cycle is in RUN.

Configuration
REQ-033 Macro YSYX_2022040010_CTRL_PERF_EN: when defined, the counters are built as described in REQ-029.
REQ-034 Without YSYX_2022040010_CTRL_PERF_EN: the counters are omitted and perf_* outputs are tied to constant 0; all other behaviour is identical.

Verification
REQ-035 id_load_use high for 1 cycle -> stall = 00011, flush = 00100 for exactly that cycle, then 0.
REQ-036 dmem_req = 1, dmem_ready = 0 for 3 cycles while ex_br_taken = 1 -> stall = 01111, flush = 10000 for 3 cycles, then flush = 00110 in the 4th cycle.
REQ-037 iwait with ex_br_taken, imem_ready arriving 2 cycles later -> state DROP, flush[1] = 1 on the ready cycle, then RUN.
REQ-038 wb_ebreak pulse -> halt = 1 and stall = 11111 from that cycle on, and held; async rst mid-cycle -> halt = 0 before the next edge.
REQ-039 PERF_EN defined, perf_cycle preset near 2^CNT_W-1 via forced state -> wraps to 0; PERF_EN undefined -> all perf_* = 0 after 100 cycles.
